sound_arbiter: RTL and testbench
================================

# sound_arbiter

Shares the single tone generator between all in-game sound sources (character hit, bubble hit, bubble pop, level clear). It latches one-cycle event pulses into a pending set, grants the highest-priority pending source, and drives `play`/`tone` for that source's fixed duration measured in timebase ticks. A one-tick silent gap follows each sound. It sits between the game-logic collision and event detectors and the audio tone generator.

## Interface
- `NUM_REQ`, 4: number of requesters. Index 0 has the highest priority.
- `DUR_W`, 4: width of the duration counter in ticks.
- `clk` input, 1: system clock.
- `resetN` input, 1: asynchronous, active-low reset.
- `tick` input, 1: timebase strobe. One `clk` cycle wide, periodic.
- `enable` input, 1: sound enable. 0 = muted.
- `req` input, `NUM_REQ`: event pulses, one bit per source. Each pulse may be 1 cycle or longer.
- `play` output, 1: tone generator enable. Registered.
- `tone` output, 4: tone index for the tone generator. Registered.
- `busy` output, 1: high in PLAY or GAP.
- `active_id` output, `$clog2(NUM_REQ)`: id of the granted source. Holds its last value when idle.

## Operation
- **Pending register** `pend[NUM_REQ-1:0]`.
  - Sets: `pend[i]` is set on any cycle where `req[i]=1` and `enable=1`.
  - Clears: `pend[i]` is cleared on the cycle it is granted. If `req[i]` is high in that same cycle, the set wins and the bit stays 1, so the sound replays later.
  - Requests while `enable=0` are dropped.
- **State machine** {IDLE, PLAY, GAP}:
  - **IDLE**: `play=0`. If `enable` and `pend!=0`:
    - grant `g` = lowest set index;
    - load `cnt` = `max(DUR[g],1)`;
    - latch `active_id=g` and `tone=TONE[g]`;
    - clear `pend[g]`;
    - go to PLAY.
  - **PLAY**: `play=1`. On `tick`, `cnt` decrements. On `tick` with `cnt==1`, go to GAP. There is no preemption: higher-priority requests arriving now wait in `pend`.
  - **GAP**: `play=0`. On the next `tick`, go to IDLE.
- **Disable**: `enable=0` in any state forces IDLE on the next clock, with `play=0` and `pend` cleared.
- **Repeats**: a request for the id currently playing sets its pending bit; it replays after the GAP.
- **Duration**: `DUR[g]` ticks. The first tick period may be partial because the grant is asynchronous to `tick`. Duration 0 is treated as 1.
- **Default decode**: an illegal state decodes to IDLE.

## Timing
- **Reset values**: state=IDLE, `pend=0`, `cnt=0`, `play=0`, `tone=0`, `busy=0`, `active_id=0`.
- **Start latency**:
  - `req` high at cycle n sets `pend` at n+1.
  - IDLE grants at the n+1 edge.
  - `play=1` and the valid `tone` appear at n+2.
- **Stop**: `play` falls in the cycle after the `tick` on which `cnt==1`.
- **Back-to-back**: the next grant happens in the cycle after GAP exits. Minimum spacing between sounds is one full tick period plus 1 clock.
- **Simultaneous events**:
  - `req` and `tick` in the same cycle are independent.
  - Multiple `req` bits in one cycle all become pending and are served in index order.
- **Mid-operation reset**: all outputs return to their reset values immediately (asynchronous).

## Structure
- Package `sound_pkg`:
  - `sound_id_t` enum: CHAR_HIT=0, BUBBLE_HIT=1, POP=2, LEVEL_CLR=3.
  - `TONE[]` constant table: 3, 5, 8, 12.
  - `DUR[]` constant table: 2, 2, 1, 6 ticks.
  - State enum `snd_st_t`.
- Sub-module `prio_encoder`: parameterised on `NUM_REQ`. Outputs `valid` and the lowest set index.

## Test plan
- `req[0]` pulse at cycle 10, `tick` every 8 clocks → `play=1` and `tone=3` at cycle 12, `active_id=0`. `play` falls after the second tick, followed by one silent tick, then `busy=0`.
- `req=4'b1010` in one cycle → BUBBLE_HIT plays first (`tone=5`, 2 ticks), then GAP, then LEVEL_CLR (`tone=12`, 6 ticks). `pend=0` at the end.
- `req[3]` playing, then `req[0]` arrives mid-sound → LEVEL_CLR completes all 6 ticks uninterrupted, then CHAR_HIT plays after the GAP.
- `req[1]` re-pulsed while id 1 is playing, including on the grant cycle → id 1 plays twice, separated by a GAP.
- `enable` dropped mid-PLAY with `pend[2]` set → `play=0` next clock, state IDLE, `pend=0`. `req` pulses while `enable=0` produce no sound after re-enable.
- `resetN` asserted during PLAY → `play`, `tone`, `busy` and `active_id` read 0 immediately. After release there is no output until a new `req`.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types and constant tables for the sound arbiter.
// Contents:
//   sound_id_t           : the sound source ids; the id is also the priority (0 = highest).
//   snd_st_t             : arbiter state encoding.
//   TONE / DUR           : per-source tone index and duration in timebase ticks.
//   tone_of() / dur_of() : table lookups by source id.
package sound_pkg;

    localparam int NUM_SOUNDS = 4;
    localparam int SND_ID_W   = 2;

    typedef enum logic [SND_ID_W-1:0] {
        CHAR_HIT   = 2'd0,
        BUBBLE_HIT = 2'd1,
        POP        = 2'd2,
        LEVEL_CLR  = 2'd3
    } sound_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } snd_st_t;

    localparam logic [3:0] TONE [NUM_SOUNDS] = '{4'd3, 4'd5, 4'd8, 4'd12};
    localparam logic [3:0] DUR  [NUM_SOUNDS] = '{4'd2, 4'd2, 4'd1, 4'd6};

    function automatic logic [3:0] tone_of(input logic [SND_ID_W-1:0] id);
        return TONE[id];
    endfunction

    function automatic logic [3:0] dur_of(input logic [SND_ID_W-1:0] id);
        return DUR[id];
    endfunction

endpackage

// File: rtl/sound_arbiter_prio_encoder.sv
// Fixed-priority encoder: reports whether any request bit is set and the
// index of the lowest set bit (index 0 wins).
// Ports:
//   req_vec [NUM_REQ-1:0] : request vector
//   valid                 : at least one bit of req_vec is set
//   idx     [ID_W-1:0]    : lowest set index (0 when nothing is set)
module prio_encoder #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_vec,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    // Scan from the top down so that the lowest set index is the last one written.
    always_comb begin
        valid = |req_vec;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = req_vec[i] ? ID_W'(i) : idx;
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// Sound arbiter: shares one tone generator between the game sound sources.
// Event pulses are latched into a pending set; the lowest-index pending
// source is granted and played for its fixed tick count, then one silent
// tick (GAP) follows before the next grant. There is no preemption.
// Ports:
//   clk       : system clock
//   resetN    : asynchronous active-low reset
//   tick      : one-cycle timebase strobe
//   enable    : sound enable; 0 mutes, drops pending events and returns to IDLE
//   req       : per-source event pulses
//   play      : tone generator enable (registered)
//   tone      : tone index of the playing source (registered, held when idle)
//   busy      : high while playing or in the silent gap (registered)
//   active_id : id of the granted source (registered, held when idle)
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       tick,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req,
    output logic                       play,
    output logic [3:0]                 tone,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    snd_st_t            state_r;
    snd_st_t            state_nxt_s;
    logic [NUM_REQ-1:0] pend_r;
    logic [NUM_REQ-1:0] pend_nxt_s;
    logic [NUM_REQ-1:0] grant_mask_s;
    logic [DUR_W-1:0]   cnt_r;
    logic [DUR_W-1:0]   cnt_nxt_s;
    logic [3:0]         tone_r;
    logic [3:0]         tone_nxt_s;
    logic [ID_W-1:0]    active_id_r;
    logic [ID_W-1:0]    active_id_nxt_s;
    logic               play_r;
    logic               play_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;
    logic               grant_s;
    logic               pend_valid_s;
    logic [ID_W-1:0]    grant_idx_s;
    logic [3:0]         dur_g_s;

    prio_encoder #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_prio (
        .req_vec (pend_r),
        .valid   (pend_valid_s),
        .idx     (grant_idx_s)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a grant is issued only on the IDLE->PLAY transition.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pend_valid_s) begin
                        state_nxt_s = ST_PLAY;
                        grant_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (tick && (cnt_r == DUR_W'(1'b1))) begin
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_GAP;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output and datapath next values. A request arriving on its own grant
    // cycle is OR-ed back in after the clear, so it replays later.
    always_comb begin
        dur_g_s         = dur_of(SND_ID_W'(grant_idx_s));
        grant_mask_s    = grant_s ? (NUM_REQ'(1'b1) << grant_idx_s) : '0;
        pend_nxt_s      = pend_r;
        cnt_nxt_s       = cnt_r;
        tone_nxt_s      = tone_r;
        active_id_nxt_s = active_id_r;
        if (!enable) begin
            pend_nxt_s = '0;
            cnt_nxt_s  = '0;
        end else begin
            pend_nxt_s = (pend_r & ~grant_mask_s) | req;
            if (grant_s) begin
                // A zero-length entry still plays for one tick.
                cnt_nxt_s       = (dur_g_s == 4'd0) ? DUR_W'(1'b1) : DUR_W'(dur_g_s);
                tone_nxt_s      = tone_of(SND_ID_W'(grant_idx_s));
                active_id_nxt_s = grant_idx_s;
            end else if ((state_r == ST_PLAY) && tick) begin
                cnt_nxt_s = cnt_r - DUR_W'(1'b1);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end
        play_nxt_s = (state_nxt_s == ST_PLAY);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_r      <= '0;
            cnt_r       <= '0;
            tone_r      <= 4'd0;
            active_id_r <= '0;
            play_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            pend_r      <= pend_nxt_s;
            cnt_r       <= cnt_nxt_s;
            tone_r      <= tone_nxt_s;
            active_id_r <= active_id_nxt_s;
            play_r      <= play_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign play      = play_r;
    assign tone      = tone_r;
    assign busy      = busy_r;
    assign active_id = active_id_r;

endmodule

// File: tb/tb_sound_arbiter.sv
// Testbench for sound_arbiter. Stimulus pushes the expected sounds
// (id, tone, tick count) into a queue; a monitor pops an entry whenever
// play rises and checks the id/tone, then the tick count and the silent
// gap when play falls. A tick count of 0 marks a sound expected to be cut short.
`timescale 1ns/1ps
module tb_sound_arbiter;
    import sound_pkg::*;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic       tick   = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req    = 4'b0000;
    logic       play;
    logic [3:0] tone;
    logic       busy;
    logic [1:0] active_id;

    int checks = 0;
    int errors = 0;
    int tick_phase = 0;

    typedef struct {
        logic [1:0] id;
        logic [3:0] tone;
        int         dur;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic in_play    = 1'b0;
    int   ticks_seen = 0;

    sound_arbiter #(.NUM_REQ(4), .DUR_W(4)) dut (
        .clk       (clk),
        .resetN    (resetN),
        .tick      (tick),
        .enable    (enable),
        .req       (req),
        .play      (play),
        .tone      (tone),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    // Timebase: one tick every 8 clocks.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick = (tick_phase == 7);
            tick_phase = (tick_phase + 1) % 8;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_snd(input logic [1:0] id, input logic [3:0] t, input int d);
        exp_t e;
        e.id   = id;
        e.tone = t;
        e.dur  = d;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [3:0] m, input int n);
        req = m;
        repeat (n) @(posedge clk);
        #1;
        req = 4'b0000;
    endtask

    task automatic wait_play(input string name);
        int n = 0;
        while (!play && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(play), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || play) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, (exp_q.size() == 0 && !busy && !play) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Monitor: sound starts and ends.
    initial begin
        forever begin
            @(negedge clk);
            if (play && !in_play) begin
                in_play    = 1'b1;
                ticks_seen = tick ? 1 : 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    cur.dur = 0;
                    $display("FAIL unexpected_sound: got id %0d tone %0d, expected no sound",
                             active_id, tone);
                end else begin
                    cur = exp_q.pop_front();
                    check("sound_id", 32'(active_id), 32'(cur.id));
                    check("sound_tone", 32'(tone), 32'(cur.tone));
                end
            end else if (play && in_play) begin
                if (tick) ticks_seen++;
            end else if (!play && in_play) begin
                in_play = 1'b0;
                if (cur.dur != 0) begin
                    check("sound_ticks", 32'(ticks_seen), 32'(cur.dur));
                    check("gap_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_play", 32'(play), 32'd0);
        check("rst_tone", 32'(tone), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(active_id), 32'd0);
        check("rst_pend", 32'(dut.pend_r), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
        resetN = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Single CHAR_HIT: two-cycle start latency.
        expect_snd(2'd0, 4'd3, 2);
        pulse(4'b0001, 1);
        check("s1_pre_grant_play", 32'(play), 32'd0);
        @(posedge clk);
        #1;
        check("s1_play", 32'(play), 32'd1);
        check("s1_tone", 32'(tone), 32'd3);
        check("s1_id", 32'(active_id), 32'd0);
        check("s1_busy", 32'(busy), 32'd1);
        drain("s1_drain");
        check("s1_tone_held", 32'(tone), 32'd3);

        // Two sources in one cycle: served in index order.
        expect_snd(2'd1, 4'd5, 2);
        expect_snd(2'd3, 4'd12, 6);
        pulse(4'b1010, 1);
        drain("s2_drain");
        check("s2_pend_empty", 32'(dut.pend_r), 32'd0);
        check("s2_id_held", 32'(active_id), 32'd3);

        // No preemption: CHAR_HIT waits behind LEVEL_CLR.
        expect_snd(2'd3, 4'd12, 6);
        expect_snd(2'd0, 4'd3, 2);
        pulse(4'b1000, 1);
        wait_play("s3_start");
        repeat (20) @(posedge clk);
        #1;
        pulse(4'b0001, 1);
        check("s3_no_preempt_id", 32'(active_id), 32'd3);
        check("s3_no_preempt_play", 32'(play), 32'd1);
        drain("s3_drain");

        // Request held across its own grant cycle: plays twice.
        expect_snd(2'd1, 4'd5, 2);
        expect_snd(2'd1, 4'd5, 2);
        pulse(4'b0010, 2);
        drain("s4_drain");

        // Disable mid-play with POP pending.
        expect_snd(2'd3, 4'd12, 0);
        pulse(4'b1000, 1);
        wait_play("s5_start");
        pulse(4'b0100, 1);
        repeat (3) @(posedge clk);
        #1;
        check("s5_pend2_set", 32'(dut.pend_r), 32'd4);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("s5_dis_play", 32'(play), 32'd0);
        check("s5_dis_busy", 32'(busy), 32'd0);
        check("s5_dis_state", 32'(dut.state_r), 32'(ST_IDLE));
        check("s5_dis_pend", 32'(dut.pend_r), 32'd0);
        pulse(4'b0101, 1);
        repeat (2) @(posedge clk);
        #1;
        check("s5_dropped_pend", 32'(dut.pend_r), 32'd0);
        enable = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("s5_silent_play", 32'(play), 32'd0);
        check("s5_silent_busy", 32'(busy), 32'd0);

        // Asynchronous reset during play.
        expect_snd(2'd3, 4'd12, 0);
        pulse(4'b1000, 1);
        wait_play("s6_start");
        repeat (3) @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("s6_rst_play", 32'(play), 32'd0);
        check("s6_rst_tone", 32'(tone), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_id", 32'(active_id), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("s6_post_rst_play", 32'(play), 32'd0);
        check("s6_post_rst_busy", 32'(busy), 32'd0);
        expect_snd(2'd0, 4'd3, 2);
        pulse(4'b0001, 1);
        drain("s6_drain");

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
